eeprom_cmd_seq: RTL and testbench
=================================

Name: eeprom_cmd_seq

Overview:
- Command sequencer directly upstream of the SPI byte master (HW2).
- Turns single host transactions (write one byte / read one byte at an address) into the 25AA010A byte sequences:
  - Write: WREN, then WRITE + addr + data, then write-cycle wait.
  - Read: READ + addr, then one read byte.
- Drives the master's write/write_value/write_complete and read/read_value/read_complete handshakes, plus a frame-end flag so the master releases CSN.

Parameters:
- ADDR_W, 7: EEPROM address width. Upper bits of the address byte are sent as 0.
- GAP_CYC, 50: idle cycles between the WREN frame and the WRITE frame (1 us at 50 MHz).
- TWC_CYC, 250000: write-cycle wait after the data byte (5 ms at 50 MHz).
- TMO_CYC, 4096: max cycles to wait for write_complete/read_complete before aborting.

Ports:
- clk_50M, in, 1: the single clock.
- reset, in, 1: synchronous, active-high.
- req, in, 1: start transaction. Sampled only in IDLE.
- req_we, in, 1: 1 = write, 0 = read.
- req_addr, in, ADDR_W: byte address.
- req_wdata, in, 8: write data.
- busy, out, 1: high from the cycle after req is accepted until done.
- done, out, 1: one-cycle pulse at transaction end.
- err, out, 1: valid with done; 1 = handshake timeout.
- rdata, out, 8: read result; held until the next read's done.
- write, out, 1: one-cycle pulse to the master, byte in write_value.
- write_value, out, 8: byte to shift. Stable from the pulse until write_complete.
- write_complete, in, 1: master finished shifting a byte.
- read, out, 1: one-cycle pulse to the master.
- read_value, in, 8: byte received. Valid when read_complete=1.
- read_complete, in, 1: master finished a read byte.
- spi_last, out, 1: qualifies the current byte as frame end (master raises CSN after it). Stable with write_value.

Behaviour:
- Reset (synchronous, reset=1 at a clock edge):
  - Outputs: state=IDLE, busy=0, done=0, err=0, rdata=8'h00, write=0, read=0, write_value=8'h00, spi_last=0.
  - Counters cleared.
  - Mid-transaction reset aborts at that edge. No done pulse.
- FSM states: IDLE, ISSUE, WAIT, GAP, TWC, FIN.
  - Byte list (in the package): write = [06 last], GAP, [02], [addr], [data last], TWC. read = [03], [addr], [RD last].
  - A byte index (3 bits) walks the list.
- IDLE:
  - When req=1, latch req_we, req_addr (zero-extended to 8 bits) and req_wdata.
  - Go to ISSUE; busy=1 next cycle.
  - req while busy is ignored (not queued).
- ISSUE (exactly 1 cycle):
  - Write-type byte: write=1, write_value=byte, spi_last per list.
  - RD slot: read=1, spi_last=1.
  - Always proceeds to WAIT.
- WAIT:
  - Samples write_complete (write-type byte) or read_complete (RD slot). Complete inputs are never sampled in ISSUE, so a stale level from the previous byte is not counted.
  - On complete: advance the index.
  - On RD, capture rdata <= read_value in the same cycle.
  - Next state is ISSUE, GAP, TWC or FIN as the list dictates.
  - The wrong-type complete (e.g. read_complete while waiting for a write) is ignored.
- Timeout: the WAIT counter starts at 0 on entry. If it reaches TMO_CYC-1 without complete, go to FIN with err=1.
- GAP: count GAP_CYC cycles, then ISSUE. The master is idle and CSN high.
- TWC: count TWC_CYC cycles, then FIN. No SPI traffic; the EEPROM is internally programming.
- FIN: done=1 for one cycle, busy=0 the same cycle, then IDLE. A req sampled in FIN is ignored; it is accepted from IDLE the following cycle.
- Latency (write-complete returned N cycles after the pulse):
  - Write: 4 × (1+N) + GAP_CYC + TWC_CYC + 2 cycles from req to done.
  - Read: 3 × (1+N) + 2.
- err is cleared at the next req acceptance. rdata is unchanged on a write or an errored read.
- Counters are wide enough for max(TWC_CYC, TMO_CYC), i.e. $clog2 bits, with no wrap within a phase.

Decomposition:
- Package eeprom_cmd_pkg:
  - Opcodes: OP_WREN=8'h06, OP_WRITE=8'h02, OP_READ=8'h03, OP_RDSR=8'h05 (reserved).
  - FSM state enum.
  - Byte-slot kind enum: OPC/ADDR/DATA/RD/GAP/TWC.
- Sub-module eeprom_delay_ctr:
  - Loadable down-counter with load/value/zero outputs.
  - Shared by the GAP, TWC and timeout phases; only one is active at a time.

Test Plan (bench uses GAP_CYC=4, TWC_CYC=20, TMO_CYC=16):
- Write: req_we=1, addr=7'h01, data=8'h9A, with the master model returning complete 10 cycles after each pulse.
  - write_value sequence is 06(last), 02, 01, 9A(last).
  - Exactly 4 write pulses and 0 read pulses.
  - done 4×11+4+20+2=70 cycles after req, with err=0.
- Read: req_we=0, addr=7'h02, model read_value=8'hBC.
  - write_value sequence is 03, 02, then one read pulse with spi_last=1.
  - rdata=8'hBC at done; latency 3×11+2=35.
- Timeout: write_complete never returned after the first byte.
  - done with err=1 exactly 16 cycles after WAIT entry.
  - No further write pulses; busy drops with done.
- Reset mid-transaction: reset asserted in TWC, then req read of 7'h00.
  - All outputs take their reset values one edge later.
  - The next read completes normally with no leftover write pulse.
- Stale and wrong-type completes:
  - write_complete held high across the next byte's ISSUE cycle: exactly one byte advance per completion.
  - A spurious read_complete during a write WAIT is ignored.
  - A second req issued while busy is not executed.

Source files
------------

// File: rtl/eeprom_cmd_pkg.sv
// eeprom_cmd_pkg: 25AA010A opcodes, sequencer states and the per-transaction byte list.
package eeprom_cmd_pkg;
    localparam logic [7:0] OP_WREN  = 8'h06;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_RDSR  = 8'h05;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP, S_TWC, S_FIN} state_e;
    typedef enum logic [2:0] {K_OPC, K_ADDR, K_DATA, K_RD, K_GAP, K_TWC} slot_kind_e;

    // write: [06 last] GAP [02] [addr] [data last] TWC ; read: [03] [addr] [RD last]
    function automatic slot_kind_e kind_of(input logic we, input logic [2:0] idx);
        return we ? ((idx == 3'd0 || idx == 3'd2) ? K_OPC : idx == 3'd1 ? K_GAP :
                     idx == 3'd3 ? K_ADDR : idx == 3'd4 ? K_DATA : K_TWC)
                  : (idx == 3'd0 ? K_OPC : idx == 3'd1 ? K_ADDR : K_RD);
    endfunction

    function automatic logic last_of(input logic we, input logic [2:0] idx);
        return we ? (idx == 3'd0 || idx == 3'd4) : idx >= 3'd2;
    endfunction

    function automatic logic [7:0] opc_of(input logic we, input logic [2:0] idx);
        return !we ? OP_READ : idx == 3'd0 ? OP_WREN : OP_WRITE;
    endfunction
endpackage

// File: rtl/eeprom_delay_ctr.sv
// eeprom_delay_ctr: loadable down-counter shared by the gap, write-cycle and timeout phases.
module eeprom_delay_ctr #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (reset_i)
            cnt_q <= '0;
        else if (load_i)
            cnt_q <= value_i;
        else if (cnt_q != '0)
            cnt_q <= cnt_q - W'(1);
    end

    assign zero_o = cnt_q == '0;
endmodule

// File: rtl/eeprom_cmd_seq.sv
// eeprom_cmd_seq: turns single-byte host reads/writes into 25AA010A SPI byte sequences
// driving the byte master's write/read handshakes.
module eeprom_cmd_seq
    import eeprom_cmd_pkg::*;
#(
    parameter int ADDR_W  = 7,
    parameter int GAP_CYC = 50,
    parameter int TWC_CYC = 250000,
    parameter int TMO_CYC = 4096
) (
    input  logic              clk_50M_i,
    input  logic              reset_i,
    input  logic              req_i,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [7:0]        req_wdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [7:0]        rdata_o,
    output logic              write_o,
    output logic [7:0]        write_value_o,
    input  logic              write_complete_i,
    output logic              read_o,
    input  logic [7:0]        read_value_i,
    input  logic              read_complete_i,
    output logic              spi_last_o
);
    localparam int MAXC = TWC_CYC > TMO_CYC ? (TWC_CYC > GAP_CYC ? TWC_CYC : GAP_CYC)
                                            : (TMO_CYC > GAP_CYC ? TMO_CYC : GAP_CYC);
    localparam int CW = MAXC > 2 ? $clog2(MAXC) : 1;

    state_e        state_q;
    logic [2:0]    idx_q, nx_idx;
    logic          we_q, busy_q, done_q, err_q, write_q, read_q, spi_last_q;
    logic [7:0]    addr_q, wdata_q, rdata_q, write_value_q, nx_byte;
    slot_kind_e    nx_kind;
    logic          cur_rd, cmpl, go_issue, ld, zero, nx_we, nx_skip;
    logic [CW-1:0] ld_val;

    // nx_* describes the slot about to be issued; GAP/TWC slots are skipped over in the index.
    always_comb begin
        cur_rd   = kind_of(we_q, idx_q) == K_RD;
        cmpl     = state_q == S_WAIT && (cur_rd ? read_complete_i : write_complete_i);
        nx_we    = state_q == S_IDLE ? req_we_i : we_q;
        nx_idx   = state_q == S_IDLE ? 3'd0 : state_q == S_WAIT ? idx_q + 3'd1 : idx_q;
        nx_kind  = kind_of(nx_we, nx_idx);
        nx_skip  = nx_kind == K_GAP || nx_kind == K_TWC;
        nx_byte  = nx_kind == K_ADDR ? addr_q : nx_kind == K_DATA ? wdata_q : opc_of(nx_we, nx_idx);
        go_issue = (state_q == S_IDLE && req_i) || (state_q == S_GAP && zero) || (cmpl && !cur_rd && !nx_skip);
        ld       = state_q == S_ISSUE || cmpl;
        ld_val   = state_q == S_ISSUE ? CW'(TMO_CYC - 1) : nx_kind == K_GAP ? CW'(GAP_CYC - 1) : CW'(TWC_CYC - 1);
    end

    eeprom_delay_ctr #(.W(CW)) u_dly (
        .clk_i   (clk_50M_i),
        .reset_i (reset_i),
        .load_i  (ld),
        .value_i (ld_val),
        .zero_o  (zero)
    );

    always_ff @(posedge clk_50M_i) begin
        if (reset_i) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rdata_q       <= '0;
            write_value_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            write_q       <= 1'b0;
            read_q        <= 1'b0;
            spi_last_q    <= 1'b0;
        end else begin
            write_q <= go_issue && nx_kind != K_RD;
            read_q  <= go_issue && nx_kind == K_RD;
            done_q  <= 1'b0;
            if (go_issue && nx_kind != K_RD)
                write_value_q <= nx_byte;
            if (go_issue)
                spi_last_q <= last_of(nx_we, nx_idx);
            case (state_q)
                S_IDLE: if (req_i) begin
                    we_q    <= req_we_i;
                    addr_q  <= 8'(req_addr_i);
                    wdata_q <= req_wdata_i;
                    idx_q   <= '0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b1;
                    state_q <= S_ISSUE;
                end
                S_ISSUE: state_q <= S_WAIT;
                S_WAIT: if (cmpl) begin
                    idx_q <= nx_skip ? nx_idx + 3'd1 : nx_idx;
                    if (cur_rd) begin
                        rdata_q <= read_value_i;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                    state_q <= cur_rd ? S_FIN : nx_kind == K_GAP ? S_GAP : nx_kind == K_TWC ? S_TWC : S_ISSUE;
                end else if (zero) begin
                    err_q   <= 1'b1;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_FIN;
                end
                S_GAP: if (zero) state_q <= S_ISSUE;
                S_TWC: if (zero) begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_FIN;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign rdata_o       = rdata_q;
    assign write_o       = write_q;
    assign write_value_o = write_value_q;
    assign read_o        = read_q;
    assign spi_last_o    = spi_last_q;
endmodule

// File: tb/tb_eeprom_cmd_seq.sv
// tb_eeprom_cmd_seq: scoreboard bench with a byte-master model answering N cycles after each pulse.
module tb_eeprom_cmd_seq;
    localparam int N = 10;

    logic       clk = 1'b0, reset = 1'b1, req = 1'b0, req_we = 1'b0;
    logic [6:0] req_addr = '0;
    logic [7:0] req_wdata = '0, read_value = '0, rdata, write_value;
    logic       write_complete = 1'b0, read_complete = 1'b0;
    logic       busy, done, err, write, read, spi_last;

    eeprom_cmd_seq #(.ADDR_W(7), .GAP_CYC(4), .TWC_CYC(20), .TMO_CYC(16)) dut (
        .clk_50M_i(clk), .reset_i(reset), .req_i(req), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .busy_o(busy), .done_o(done),
        .err_o(err), .rdata_o(rdata), .write_o(write), .write_value_o(write_value),
        .write_complete_i(write_complete), .read_o(read), .read_value_i(read_value),
        .read_complete_i(read_complete), .spi_last_o(spi_last)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 = write pulse (val, last), 1 = read pulse (last), 2 = done (rdata, err, latency)
    typedef struct { int kind; logic [7:0] val; logic flag; int lat; } ev_t;
    ev_t exp_q[$];

    int compared = 0, mismatched = 0, wr_cnt = 0, rd_cnt = 0, req_cyc = 0;
    int wc_cnt = 0, rc_cnt = 0, spur_cyc = -1;
    bit hold_wc = 0, no_resp = 0, wc_fire = 0;
    logic [7:0] rv = 8'hBC;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        compared++;
        if (a !== e) begin
            mismatched++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", n, a, e, cyc);
        end
    endtask

    task automatic push(input int k, input logic [7:0] v, input logic f, input int l);
        ev_t e;
        e.kind = k; e.val = v; e.flag = f; e.lat = l;
        exp_q.push_back(e);
    endtask

    task automatic check_ev(input int k, input logic [7:0] v, input logic f);
        ev_t e;
        if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_event: got kind %0d val %0h, want none (cycle %0d)", k, v, cyc);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", k, e.kind);
            if (k == e.kind && k != 1) chk(k == 2 ? "rdata" : "write_value", v, e.val);
            if (k == e.kind) chk(k == 2 ? "err" : "spi_last", f, e.flag);
            if (k == e.kind && k == 2) chk("latency", cyc - req_cyc + 1, e.lat);
        end
    endtask

    // master model: complete N cycles after each pulse, optionally held one extra cycle
    always @(posedge clk) begin
        #1;
        if (reset) begin
            wc_cnt = 0; rc_cnt = 0; wc_fire = 0;
            write_complete = 1'b0; read_complete = 1'b0;
        end else begin
            write_complete = hold_wc && wc_fire;
            wc_fire = 0;
            if (wc_cnt > 0) begin
                wc_cnt--;
                if (wc_cnt == 0) begin write_complete = 1'b1; wc_fire = 1; end
            end
            if (write && !no_resp) wc_cnt = N;
            read_complete = (cyc == spur_cyc);
            read_value = 8'h00;
            if (rc_cnt > 0) begin
                rc_cnt--;
                if (rc_cnt == 0) begin read_complete = 1'b1; read_value = rv; end
            end
            if (read) rc_cnt = N;
        end
    end

    always @(posedge clk) begin
        #1;
        if (!reset) begin
            if (write) begin wr_cnt++; check_ev(0, write_value, spi_last); end
            if (read) begin rd_cnt++; check_ev(1, 8'h00, spi_last); end
            if (done) begin check_ev(2, rdata, err); chk("busy_at_done", busy, 0); end
        end
    end

    task automatic check_reset();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_write", write, 0);
        chk("rst_read", read, 0);
        chk("rst_write_value", write_value, 0);
        chk("rst_spi_last", spi_last, 0);
    endtask

    task automatic do_req(input logic we, input logic [6:0] a, input logic [7:0] d);
        @(negedge clk);
        req = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        req_cyc = cyc; wr_cnt = 0; rd_cnt = 0;
        @(negedge clk);
        req = 1'b0;
        chk("busy_after_req", busy, 1);
        chk("err_cleared", err, 0);
    endtask

    task automatic wait_drain(input int max_cyc);
        for (int i = 0; i < max_cyc && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, want finish by 100us");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check_reset();
        reset = 1'b0;
        // write 9A to 01: latency 4*11+4+20+2
        push(0, 8'h06, 1, 0); push(0, 8'h02, 0, 0); push(0, 8'h01, 0, 0); push(0, 8'h9A, 1, 0);
        push(2, 8'h00, 0, 70);
        do_req(1'b1, 7'h01, 8'h9A);
        wait_drain(200);
        chk("write_pulses", wr_cnt, 4);
        chk("write_read_pulses", rd_cnt, 0);
        // read from 02: latency 3*11+2
        push(0, 8'h03, 0, 0); push(0, 8'h02, 0, 0); push(1, 8'h00, 1, 0); push(2, 8'hBC, 0, 35);
        do_req(1'b0, 7'h02, 8'h00);
        wait_drain(200);
        chk("read_pulses", rd_cnt, 1);
        chk("read_write_pulses", wr_cnt, 2);
        // timeout: req, ISSUE, 16 WAIT cycles, FIN -> 19 inclusive
        no_resp = 1;
        push(0, 8'h06, 1, 0); push(2, 8'hBC, 1, 19);
        do_req(1'b1, 7'h03, 8'h11);
        wait_drain(100);
        repeat (10) @(negedge clk);
        chk("timeout_write_pulses", wr_cnt, 1);
        chk("timeout_busy", busy, 0);
        no_resp = 0;
        // reset during the write-cycle wait
        push(0, 8'h06, 1, 0); push(0, 8'h02, 0, 0); push(0, 8'h04, 0, 0); push(0, 8'h55, 1, 0);
        push(2, 8'hBC, 0, 70);
        do_req(1'b1, 7'h04, 8'h55);
        for (int i = 0; i < 200 && wr_cnt < 4; i++) @(negedge clk);
        repeat (16) @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        check_reset();
        @(negedge clk);
        reset = 1'b0;
        rv = 8'h5E;
        push(0, 8'h03, 0, 0); push(0, 8'h00, 0, 0); push(1, 8'h00, 1, 0); push(2, 8'h5E, 0, 35);
        do_req(1'b0, 7'h00, 8'h00);
        wait_drain(200);
        chk("post_reset_write_pulses", wr_cnt, 2);
        // held write_complete, spurious read_complete, and a req while busy
        hold_wc = 1;
        push(0, 8'h06, 1, 0); push(0, 8'h02, 0, 0); push(0, 8'h05, 0, 0); push(0, 8'h33, 1, 0);
        push(2, 8'h5E, 0, 70);
        do_req(1'b1, 7'h05, 8'h33);
        spur_cyc = cyc + 3;
        @(negedge clk);
        req = 1'b1; req_we = 1'b0; req_addr = 7'h7F;
        @(negedge clk);
        req = 1'b0;
        wait_drain(200);
        hold_wc = 0;
        repeat (40) @(negedge clk);
        chk("stale_write_pulses", wr_cnt, 4);
        chk("stale_read_pulses", rd_cnt, 0);
        chk("idle_after_ignored_req", busy, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
